// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: circular queue taking up to two
// entries per cycle and presenting the two oldest in program order.
package inst_buffer_pkg;
    typedef enum logic [3:0] {
        EXC_NONE = 4'd0,
        EXC_PIF  = 4'd1,
        EXC_ADEF = 4'd2,
        EXC_TLBR = 4'd3,
        EXC_PPI  = 4'd4
    } exception_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        exc;
        exception_t  exc_type;
    } ibuf_entry_t;
endpackage

module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  input_size,
    input  logic [31:0] pc1,
    input  logic [31:0] inst1,
    input  logic        pred_branch_taken1,
    input  logic [31:0] pred_branch_target1,
    input  logic [31:0] pc2,
    input  logic [31:0] inst2,
    input  logic        pred_branch_taken2,
    input  logic [31:0] pred_branch_target2,
    input  logic        have_exception,
    input  exception_t  exception_type,
    output logic        ibuf_ready,
    input  logic        flush,
    output logic        out_valid1,
    output logic        out_valid2,
    output logic [31:0] out_pc1,
    output logic [31:0] out_pc2,
    output logic [31:0] out_inst1,
    output logic [31:0] out_inst2,
    output logic        out_pred_branch_taken1,
    output logic        out_pred_branch_taken2,
    output logic [31:0] out_pred_branch_target1,
    output logic [31:0] out_pred_branch_target2,
    output logic        out_have_exception1,
    output logic        out_have_exception2,
    output exception_t  out_exception_type1,
    output exception_t  out_exception_type2,
    input  logic [1:0]  pop_size
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ibuf_entry_t r_mem [DEPTH];
    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;
    logic          r_exc_lock;

    logic [1:0]    w_push_req, w_push_n, w_pop_n, w_avail;
    logic [CW:0]   w_room;
    logic [PW-1:0] w_tail1, w_head1;
    ibuf_entry_t   w_ent1, w_ent2, w_out1, w_out2;

    assign w_tail1 = r_tail + PW'(1);
    assign w_head1 = r_head + PW'(1);

    // An exception entry always goes in alone; the lock then blocks duplicates.
    always_comb begin
        w_push_req = 2'd0;
        if (!r_exc_lock && !flush) begin
            if (have_exception)        w_push_req = 2'd1;
            else if (input_size[1])    w_push_req = 2'd2;
            else                       w_push_req = input_size;
        end
    end

    assign w_avail = (r_count >= CW'(2)) ? 2'd2 : r_count[1:0];

    always_comb begin
        w_pop_n = 2'd0;
        if (!flush) w_pop_n = (pop_size < w_avail) ? pop_size : w_avail;
    end

    // Free slots after this cycle's pop; pushes beyond it are dropped, entry 2 first.
    assign w_room   = (CW+1)'(DEPTH) - {1'b0, r_count} + {{(CW-1){1'b0}}, w_pop_n};
    assign w_push_n = ({{(CW-1){1'b0}}, w_push_req} > w_room) ? w_room[1:0] : w_push_req;

    always_comb begin
        w_ent1             = '0;
        w_ent1.pc          = pc1;
        w_ent1.inst        = inst1;
        w_ent1.pred_taken  = pred_branch_taken1;
        w_ent1.pred_target = pred_branch_target1;
        w_ent1.exc         = have_exception;
        w_ent1.exc_type    = have_exception ? exception_type : EXC_NONE;
        w_ent2             = '0;
        w_ent2.pc          = pc2;
        w_ent2.inst        = inst2;
        w_ent2.pred_taken  = pred_branch_taken2;
        w_ent2.pred_target = pred_branch_target2;
        w_ent2.exc_type    = EXC_NONE;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (w_push_n != 2'd0 && r_tail == PW'(gi))
                    r_mem[gi] <= w_ent1;
                else if (w_push_n == 2'd2 && w_tail1 == PW'(gi))
                    r_mem[gi] <= w_ent2;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_exc_lock <= 1'b0;
        end else if (flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_exc_lock <= 1'b0;
        end else begin
            r_head  <= r_head + PW'(w_pop_n);
            r_tail  <= r_tail + PW'(w_push_n);
            r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
            if (have_exception && w_push_req != 2'd0)
                r_exc_lock <= 1'b1;
        end
    end

    assign w_out1 = r_mem[r_head];
    assign w_out2 = r_mem[w_head1];

    assign out_valid1              = (r_count >= CW'(1));
    assign out_valid2              = (r_count >= CW'(2));
    assign out_pc1                 = w_out1.pc;
    assign out_pc2                 = w_out2.pc;
    assign out_inst1               = w_out1.inst;
    assign out_inst2               = w_out2.inst;
    assign out_pred_branch_taken1  = w_out1.pred_taken;
    assign out_pred_branch_taken2  = w_out2.pred_taken;
    assign out_pred_branch_target1 = w_out1.pred_target;
    assign out_pred_branch_target2 = w_out2.pred_target;
    assign out_have_exception1     = w_out1.exc;
    assign out_have_exception2     = w_out2.exc;
    assign out_exception_type1     = w_out1.exc_type;
    assign out_exception_type2     = w_out2.exc_type;

    // Four-slot margin leaves room for a response landing as the next request issues.
    assign ibuf_ready = !reset && !r_exc_lock && (r_count <= CW'(DEPTH - 4));
endmodule

// File: doc/inst_buffer.md
# inst_buffer

Instruction buffer between the fetch unit and decode. Each cycle it accepts 0, 1 or 2 fetched instructions (PC, instruction word, branch prediction, fetch exception) and presents the oldest 1 or 2 buffered entries to decode in program order. Decode takes them with a variable-size pop. On a branch mispredict or exception redirect, a flush empties the buffer in one cycle. Backpressure to fetch is conservative, so that the single in-flight fetch response always has room when it lands.

## Interface
- DEPTH, 8, entry count; power of two, ≥4
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- input_size  in  2  entries pushed this cycle: 0, 1 or 2 (3 treated as 2)
- pc1, inst1, pred_branch_taken1, pred_branch_target1  in  32/32/1/32  first pushed entry
- pc2, inst2, pred_branch_taken2, pred_branch_target2  in  32/32/1/32  second pushed entry (used only when input_size=2)
- have_exception  in  1  first pushed entry carries a fetch exception
- exception_type  in  exception_t  fetch exception code for entry 1
- ibuf_ready  out  1  fetch may issue a new request
- flush  in  1  discard all contents (branch_mistaken || raise_exception)
- out_valid1, out_valid2  out  1  head and head+1 entries valid; out_valid2 implies out_valid1
- out_pc1/2, out_inst1/2, out_pred_branch_taken1/2, out_pred_branch_target1/2  out  32/32/1/32  head entries
- out_have_exception1/2  out  1  entry carries exception
- out_exception_type1/2  out  exception_t  exception code
- pop_size  in  2  entries consumed by decode this cycle

## Operation
- Circular storage of DEPTH entries. Each entry holds {pc, inst, pred_taken, pred_target, exc, exc_type}.
- State: head and tail pointers, each log2(DEPTH) bits, wrapping modulo DEPTH. Count, log2(DEPTH)+1 bits. exc_lock, 1 bit.
- Push:
  - push_n = min(input_size, 2); forced to 0 when exc_lock=1 or flush=1.
  - Entry 1 is written at tail and entry 2 at tail+1 (mod DEPTH). tail advances by push_n.
  - Entry 2 is written with exc=0.
  - If have_exception=1, push_n is treated as 1 regardless of input_size. Entry 1 is written with exc=1 and exc_type. exc_lock is then set.
- exc_lock:
  - While set, all pushes are ignored and ibuf_ready=0. This stops fetch from refilling the buffer with duplicate exception entries.
  - Cleared only by flush or reset.
- Pop:
  - avail = min(count, 2). pop_n = min(pop_size, avail); any excess pop_size is ignored. pop_n is forced to 0 on flush.
  - head advances by pop_n.
- Count: count_next = count + push_n − pop_n.
- Overflow: if push_n exceeds DEPTH − count + pop_n, the excess entries are dropped (entry 2 first) and count saturates at DEPTH. This is a protocol violation and must not occur when fetch obeys ibuf_ready.
- Outputs:
  - out_valid1 = (count≥1). out_valid2 = (count≥2).
  - Data is read combinationally from head and head+1 (mod DEPTH).
  - Data on invalid slots is don't-care.
- ibuf_ready = !reset && !exc_lock && (count ≤ DEPTH−4).
  - It depends on registered state only; there is no combinational path from input_size or pop_size.
  - The 4-entry margin covers one response landing in the same cycle that fetch issues its next request.
- Flush: head, tail and count go to 0 and exc_lock goes to 0. Pushes and pops in the flush cycle are discarded.

## Timing
- Async reset: head=tail=count=0 and exc_lock=0. out_valid1/2=0 immediately. ibuf_ready=0 while reset is high and 1 in the first cycle after release.
- Push-to-output latency is 1 cycle; there is no bypass. An entry pushed in cycle t can appear at out_*1 no earlier than t+1.
- Push and pop in the same cycle are both applied; pop acts on pre-push contents.
- Flush takes effect at the next edge: out_valid1/2=0 in cycle t+1 and ibuf_ready=1 in t+1.
- Wrap-around is transparent: a two-entry push at tail=DEPTH−1 writes slot DEPTH−1 and slot 0.
- ibuf_ready reflects count after the previous edge. A pop in cycle t raises ready at t+1.

## Test plan
- Reset, then push 2 entries (pc 0x1c000000 and 0x1c000004) -> next cycle out_valid1=out_valid2=1 with those PCs in order. pop_size=2 -> both out_valid low the following cycle.
- DEPTH=8: push 2 per cycle with no pops -> ibuf_ready drops once count=6. Continue 1 more push of 2 -> count=8 with no loss. Pop 1 -> ibuf_ready stays 0 (count 7). Pop 3 more -> ready returns.
- Push with have_exception=1, input_size=1, exception_type=PIF, held for 5 cycles -> exactly one entry with out_have_exception1=1, out_exception_type1=PIF. ibuf_ready=0 until flush.
- Preload 6 entries, then assert flush together with push size 2 and pop_size 2 -> next cycle count=0, out_valid1=0, ibuf_ready=1, exc_lock clear.
- Drive head/tail to 7, push 2 entries, pop 1 per cycle -> PCs emerge in push order across the wrap. pop_size=2 with count=1 pops only 1.
- Assert reset asynchronously mid-stream with count=5 -> out_valid1/2 fall without a clock edge. After release, count=0 and ibuf_ready=1.
